// File: rtl/rca_seq_ctrl.sv
// Sequential WIDTH-bit adder on one shared CHUNK-bit rca, LSB chunk first; out_valid rises NCHUNK edges after accept.
// in_ready only in IDLE, result held in DONE until out_ready; `define RCA_SEQ_OVF_EN adds the signed-overflow output ovf.

// Combinational N-bit ripple-carry adder; zero latency, no flow control.
module rca #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);
  logic [N:0] c;

  assign c[0] = ci;
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[N];
endmodule

module rca_seq_ctrl #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef RCA_SEQ_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

  if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("rca_seq_ctrl: WIDTH must be a non-zero multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nstate;

  logic [WIDTH-1:0] op_a, op_b;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic [CHUNK-1:0] ch_a, ch_b, ch_s;
  logic             ch_co;
  logic             last;

  always_comb begin
    ch_a = '0;
    ch_b = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == IDXW'(i)) begin
        ch_a = op_a[i*CHUNK +: CHUNK];
        ch_b = op_b[i*CHUNK +: CHUNK];
      end
    end
  end

  rca #(.N(CHUNK)) u_rca (
    .a  (ch_a),
    .b  (ch_b),
    .ci (carry),
    .s  (ch_s),
    .co (ch_co)
  );

  assign last = (idx == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (in_valid)  nstate = RUN;
      RUN:     if (last)      nstate = DONE;
      DONE:    if (out_ready) nstate = IDLE;
      default:                nstate = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
  end

  // Only the chunk selected by idx is written, so partial results stay visible during RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            idx   <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NCHUNK; i++) begin
            if (idx == IDXW'(i)) sum[i*CHUNK +: CHUNK] <= ch_s;
          end
          carry <= ch_co;
          idx   <= idx + 1'b1;
          if (last) cout <= ch_co;
        end
        default: ;
      endcase
    end
  end

`ifdef RCA_SEQ_OVF_EN
  // Carry into the top bit is recovered from its sum bit: c = a ^ b ^ s.
  logic c_msb;
  assign c_msb = ch_a[CHUNK-1] ^ ch_b[CHUNK-1] ^ ch_s[CHUNK-1];

  always_ff @(posedge clk) begin
    if (rst)                       ovf <= 1'b0;
    else if (state == RUN && last) ovf <= c_msb ^ ch_co;
  end
`endif
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Randomized self-checking bench for rca_seq_ctrl against a plain-arithmetic adder model.
module tb_rca_seq_ctrl;
  localparam int W   = 64;
  localparam int C   = 16;
  localparam int NCH = W / C;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [W-1:0] a, b, sum;
`ifdef RCA_SEQ_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;
  int acc_cnt = 0;
  int hs_cnt  = 0;

  always #5 clk = ~clk;

  rca_seq_ctrl #(.WIDTH(W), .CHUNK(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef RCA_SEQ_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  always @(posedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready)   acc_cnt++;
      if (out_valid && out_ready) hs_cnt++;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] s);
    return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Starts and ends just after a falling edge. lat = rising edges from accept to out_valid.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input bit consume, input bit noise, input int hold,
                        output int lat, output logic [W-1:0] rs, output logic rc, output logic ro);
    int n;
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      if (noise) begin
        in_valid = 1'($urandom); a = rnd64(); b = rnd64(); cin = 1'($urandom);
        out_ready = 1'($urandom);
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    rs = sum; rc = cout;
`ifdef RCA_SEQ_OVF_EN
    ro = ovf;
`else
    ro = 1'b0;
`endif
    if (consume) begin
      repeat (hold) begin
        if (noise) begin in_valid = 1'($urandom); a = rnd64(); b = rnd64(); end
        @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if ({cout, sum} !== '0) begin bad++; $display("FAIL reset_sum got=%b_%h want=0", cout, sum); end
  endtask

  task automatic test_chunk_carry();
    int lat; logic [W-1:0] rs; logic rc, ro;
    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1, 0, 0, lat, rs, rc, ro);
    total++; if (lat !== NCH) begin bad++; $display("FAIL chunk_latency got=%0d want=%0d", lat, NCH); end
    total++; if (rs !== 64'h0000_0000_0001_0000) begin bad++; $display("FAIL chunk_sum got=%h want=%h", rs, 64'h10000); end
    total++; if (rc !== 1'b0) begin bad++; $display("FAIL chunk_cout got=%b want=0", rc); end
  endtask

  task automatic test_full_ripple();
    int lat; logic [W-1:0] rs; logic rc, ro;
    run_op('1, '0, 1'b1, 1, 0, 0, lat, rs, rc, ro);
    total++; if (rs !== '0) begin bad++; $display("FAIL ripple_sum got=%h want=0", rs); end
    total++; if (rc !== 1'b1) begin bad++; $display("FAIL ripple_cout got=%b want=1", rc); end
`ifdef RCA_SEQ_OVF_EN
    total++; if (ro !== 1'b0) begin bad++; $display("FAIL ripple_ovf got=%b want=0", ro); end
`endif
  endtask

  task automatic test_backpressure();
    int lat; logic [W-1:0] rs, ta, tb_v, na, nb; logic rc, ro; logic [W:0] exp;
    ta = rnd64(); tb_v = rnd64();
    exp = ref_add(ta, tb_v, 1'b1);
    run_op(ta, tb_v, 1'b1, 0, 0, 0, lat, rs, rc, ro);
    total++; if ({rc, rs} !== exp) begin bad++; $display("FAIL bp_result got=%h want=%h", {rc, rs}, exp); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = rnd64(); b = rnd64();
      @(negedge clk);
      total++; if ({cout, sum} !== exp) begin bad++; $display("FAIL bp_hold_sum got=%h want=%h", {cout, sum}, exp); end
      total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        bad++; $display("FAIL bp_hold_flags in_ready=%b out_valid=%b want 0/1", in_ready, out_valid);
      end
    end
    na = rnd64(); nb = rnd64();
    a = na; b = nb; cin = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL bp_release in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
    end
    exp = ref_add(na, nb, 1'b0);
    run_op(na, nb, 1'b0, 1, 0, 0, lat, rs, rc, ro);
    total++; if (lat !== NCH) begin bad++; $display("FAIL bp_next_latency got=%0d want=%0d", lat, NCH); end
    total++; if ({rc, rs} !== exp) begin bad++; $display("FAIL bp_next_result got=%h want=%h", {rc, rs}, exp); end
  endtask

  task automatic test_mid_reset();
    int lat; logic [W-1:0] rs; logic rc, ro;
    a = rnd64(); b = rnd64(); cin = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mrst_busy_before got=%b want=1", busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL mrst_flags in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
    end
    total++; if ({cout, sum} !== '0) begin bad++; $display("FAIL mrst_sum got=%h want=0", {cout, sum}); end
    run_op(64'd5, 64'd7, 1'b0, 1, 0, 0, lat, rs, rc, ro);
    total++; if ({rc, rs} !== 65'd12) begin bad++; $display("FAIL mrst_after_op got=%h want=c", {rc, rs}); end
    total++; if (lat !== NCH) begin bad++; $display("FAIL mrst_latency got=%0d want=%0d", lat, NCH); end
  endtask

`ifdef RCA_SEQ_OVF_EN
  task automatic test_ovf();
    int lat; logic [W-1:0] rs; logic rc, ro;
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1, 0, 0, lat, rs, rc, ro);
    total++; if ({ro, rc, rs} !== {1'b1, 1'b0, 64'h8000_0000_0000_0000}) begin
      bad++; $display("FAIL ovf_pos got ovf=%b cout=%b sum=%h want 1/0/8000000000000000", ro, rc, rs);
    end
    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1, 0, 0, lat, rs, rc, ro);
    total++; if ({ro, rc, rs} !== {1'b1, 1'b1, 64'h0}) begin
      bad++; $display("FAIL ovf_neg got ovf=%b cout=%b sum=%h want 1/1/0", ro, rc, rs);
    end
  endtask
`endif

  task automatic test_random();
    int lat, acc0, hs0; logic [W-1:0] rs, ta, tb_v; logic rc, ro, tc; logic [W:0] exp, prev;
    bit have_prev;
    have_prev = 0; prev = '0;
    acc0 = acc_cnt; hs0 = hs_cnt;
    for (int k = 0; k < 1000; k++) begin
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'b0; a = rnd64(); b = rnd64(); out_ready = 1'($urandom);
        @(negedge clk);
        if (have_prev) begin
          total++; if ({cout, sum} !== prev) begin bad++; $display("FAIL rnd_idle_hold op=%0d got=%h want=%h", k, {cout, sum}, prev); end
        end
      end
      ta = rnd64(); tc = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       tb_v = ~ta;
        1:       tb_v = '0 - ta;
        default: tb_v = rnd64();
      endcase
      exp = ref_add(ta, tb_v, tc);
      run_op(ta, tb_v, tc, 1, 1, $urandom_range(0, 3), lat, rs, rc, ro);
      total++; if (lat !== NCH) begin bad++; $display("FAIL rnd_latency op=%0d got=%0d want=%0d", k, lat, NCH); end
      total++; if ({rc, rs} !== exp) begin bad++; $display("FAIL rnd_result op=%0d got=%h want=%h", k, {rc, rs}, exp); end
`ifdef RCA_SEQ_OVF_EN
      total++; if (ro !== ref_ovf(ta, tb_v, exp[W-1:0])) begin bad++; $display("FAIL rnd_ovf op=%0d got=%b", k, ro); end
`else
      if (ref_ovf(ta, tb_v, exp[W-1:0]) && ro) $display("note: unexpected ovf value");
`endif
      prev = exp; have_prev = 1;
    end
    total++; if (acc_cnt - acc0 !== 1000) begin bad++; $display("FAIL rnd_accept_count got=%0d want=1000", acc_cnt - acc0); end
    total++; if (hs_cnt - hs0 !== 1000) begin bad++; $display("FAIL rnd_result_count got=%0d want=1000", hs_cnt - hs0); end
  endtask

  initial begin
    test_reset();
    test_chunk_carry();
    test_full_ripple();
    test_backpressure();
    test_mid_reset();
`ifdef RCA_SEQ_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
